bp_fe_fetch_replay_queue: RTL and testbench
===========================================

Name: bp_fe_fetch_replay_queue

Overview:
- Sits directly downstream of the I$ response port (vaddr, data, miss_not_data) and feeds fetched instructions to the decode/issue side.
- Buffers hit responses in order in a small FIFO.
- On a miss response, it issues a refetch of the missing vaddr upstream with fill set. It drops stale responses until the refetched vaddr returns, then resumes normal buffering.

Parameters:
vaddr_width_p, 39, virtual address width
instr_width_p, 32, instruction width
els_p, 4, FIFO depth; power of two, >= 2
count_width_p, 16, width of saturating miss counter

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
resp_v_i  in  1  I$ response valid
resp_vaddr_i  in  vaddr_width_p  response vaddr
resp_data_i  in  instr_width_p  response instruction
resp_miss_i  in  1  1 = miss_not_data response (data invalid)
resp_ready_o  out  1  accept response; handshake = resp_v_i & resp_ready_o
instr_v_o  out  1  FIFO head valid
instr_vaddr_o  out  vaddr_width_p  head vaddr
instr_o  out  instr_width_p  head instruction
instr_yumi_i  in  1  consumer dequeues head; legal only when instr_v_o
refetch_v_o  out  1  refetch request valid
refetch_vaddr_o  out  vaddr_width_p  vaddr to refetch
refetch_fill_o  out  1  fill flag to I$; equals refetch_v_o
refetch_ready_i  in  1  upstream accepts refetch
miss_count_o  out  count_width_p  saturating count of accepted miss responses

Behaviour:
- Reset (asynchronous, active-high): state=RUN, FIFO empty, miss_vaddr_r=0, counter=0.
- Outputs during and immediately after reset: instr_v_o=0, refetch_v_o=0, miss_count_o=0, resp_ready_o=1.
- FIFO:
  - Registered; enqueue in cycle N makes the entry visible on instr_v_o at N+1.
  - Order is preserved; no bypass.
  - full = els_p entries.
  - A simultaneous enqueue and dequeue when not full is legal and keeps the count unchanged.
  - When full, resp_ready_o=0 even if instr_yumi_i=1 in the same cycle.
- State RUN:
  - resp_ready_o = ~full.
  - Accepted hit (resp_miss_i=0): enqueue {vaddr, data}.
  - Accepted miss: no enqueue; miss_vaddr_r <= resp_vaddr_i; counter++ (saturates at all-ones); next state REFETCH.
- State REFETCH:
  - refetch_v_o=1, refetch_vaddr_o=miss_vaddr_r.
  - resp_ready_o=1; every accepted response is dropped, including ones matching miss_vaddr_r (stale).
  - refetch_v_o & refetch_ready_i -> WAIT.
  - refetch_v_o and refetch_vaddr_o stay stable until accepted.
- State WAIT:
  - Non-matching response (vaddr != miss_vaddr_r): resp_ready_o=1, dropped.
  - Matching response: resp_ready_o = ~full.
    - Accepted matching hit: enqueue, next state RUN.
    - Accepted matching miss: counter++, next state REFETCH (same vaddr).
- The FIFO keeps draining to the consumer in all states.
- refetch_v_o=0 in RUN and WAIT.
- A reset asserted mid-operation (any state, FIFO partially full) discards all contents on assertion.

Test Plan:
- Hits 0x1000, 0x1004, 0x1008 back-to-back, instr_yumi_i=1 -> instr_v_o from cycle after first accept; vaddr/data emerge in order; miss_count_o=0.
- els_p=4, 5 hits, yumi held 0 -> first 4 accepted; resp_ready_o=0 on 5th. Assert yumi 1 cycle -> 0x1000 pops; 5th accepted the following cycle, not the same cycle.
- Miss on 0x2000 -> refetch_v_o=1 with vaddr 0x2000, fill=1, next cycle. refetch_ready_i held 0 for 3 cycles -> stays stable. Responses 0x2004 and 0x2000 arriving in REFETCH are dropped. miss_count_o=1.
- In WAIT, responses 0x2004 (hit), then 0x2000 (hit, data 0xDEADBEEF) -> 0x2004 dropped; 0x2000 enqueued; state RUN; instr_o=0xDEADBEEF next cycle.
- In WAIT, 0x2000 returns as miss again -> back to REFETCH; refetch_vaddr_o=0x2000; miss_count_o=2.
- Reset asserted mid-WAIT with 2 FIFO entries -> instr_v_o=0, refetch_v_o=0, miss_count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_fe_fetch_replay_queue_if.sv
// I$ response, instruction delivery and refetch request signals of the fetch replay queue.
// master drives the queue's inputs (I$ side plus consumer); slave is the queue itself.
interface bp_fe_fetch_replay_queue_if #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32
);
  logic                     resp_v_i;
  logic [vaddr_width_p-1:0] resp_vaddr_i;
  logic [instr_width_p-1:0] resp_data_i;
  logic                     resp_miss_i;
  logic                     resp_ready_o;

  logic                     instr_v_o;
  logic [vaddr_width_p-1:0] instr_vaddr_o;
  logic [instr_width_p-1:0] instr_o;
  logic                     instr_yumi_i;

  logic                     refetch_v_o;
  logic [vaddr_width_p-1:0] refetch_vaddr_o;
  logic                     refetch_fill_o;
  logic                     refetch_ready_i;

  modport master (
    output resp_v_i, resp_vaddr_i, resp_data_i, resp_miss_i, instr_yumi_i, refetch_ready_i,
    input  resp_ready_o, instr_v_o, instr_vaddr_o, instr_o, refetch_v_o, refetch_vaddr_o,
           refetch_fill_o
  );

  modport slave (
    input  resp_v_i, resp_vaddr_i, resp_data_i, resp_miss_i, instr_yumi_i, refetch_ready_i,
    output resp_ready_o, instr_v_o, instr_vaddr_o, instr_o, refetch_v_o, refetch_vaddr_o,
           refetch_fill_o
  );
endinterface

// File: rtl/bp_fe_fetch_replay_queue.sv
// In-order instruction FIFO behind the I$ that replays a missed vaddr upstream and
// discards stale responses until that vaddr comes back.
module bp_fe_fetch_replay_queue #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = 4,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_fe_fetch_replay_queue_if.slave io,
  output logic [count_width_p-1:0] miss_count_o
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  typedef enum logic [1:0] {
    e_run     = 2'd0,
    e_refetch = 2'd1,
    e_wait    = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [vaddr_width_p-1:0] vaddr_mem_q [els_p];
  logic [instr_width_p-1:0] data_mem_q  [els_p];
  logic [ptr_w_lp-1:0]      rptr_q, wptr_q;
  logic [cnt_w_lp-1:0]      count_q;
  logic [vaddr_width_p-1:0] miss_vaddr_q;
  logic [count_width_p-1:0] miss_count_q;

  logic full_s, empty_s, match_s, hs_s, deq_s;
  logic ready_s, enq_s, miss_evt_s, refetch_v_s;

  assign full_s  = (count_q == els_lp);
  assign empty_s = (count_q == {cnt_w_lp{1'b0}});
  assign match_s = (io.resp_vaddr_i == miss_vaddr_q);
  assign hs_s    = io.resp_v_i & ready_s;
  assign deq_s   = io.instr_yumi_i & ~empty_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_run;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run:     if (hs_s & io.resp_miss_i) state_d = e_refetch; else state_d = state_q;
      e_refetch: if (io.refetch_ready_i) state_d = e_wait; else state_d = state_q;
      e_wait: begin
        if (hs_s & match_s) state_d = io.resp_miss_i ? e_refetch : e_run;
        else                state_d = state_q;
      end
      default:   state_d = e_run;
    endcase
  end

  // A matching response in WAIT is the only thing that can leave WAIT, so only it
  // is held off by a full FIFO; everything else there is dropped on arrival.
  always_comb begin
    ready_s     = 1'b1;
    enq_s       = 1'b0;
    miss_evt_s  = 1'b0;
    refetch_v_s = 1'b0;
    case (state_q)
      e_run: begin
        ready_s    = ~full_s;
        enq_s      = hs_s & ~io.resp_miss_i;
        miss_evt_s = hs_s & io.resp_miss_i;
      end
      e_refetch: begin
        ready_s     = 1'b1;
        refetch_v_s = 1'b1;
      end
      e_wait: begin
        ready_s    = match_s ? ~full_s : 1'b1;
        enq_s      = hs_s & match_s & ~io.resp_miss_i;
        miss_evt_s = hs_s & match_s & io.resp_miss_i;
      end
      default: begin
        ready_s     = 1'b1;
        refetch_v_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q       <= {ptr_w_lp{1'b0}};
      wptr_q       <= {ptr_w_lp{1'b0}};
      count_q      <= {cnt_w_lp{1'b0}};
      miss_vaddr_q <= {vaddr_width_p{1'b0}};
      miss_count_q <= {count_width_p{1'b0}};
    end else begin
      if (enq_s) wptr_q <= wptr_q + ptr_w_lp'(1);
      if (deq_s) rptr_q <= rptr_q + ptr_w_lp'(1);
      case ({enq_s, deq_s})
        2'b10:   count_q <= count_q + cnt_w_lp'(1);
        2'b01:   count_q <= count_q - cnt_w_lp'(1);
        default: count_q <= count_q;
      endcase
      if (miss_evt_s) miss_vaddr_q <= io.resp_vaddr_i;
      if (miss_evt_s && (miss_count_q != {count_width_p{1'b1}}))
        miss_count_q <= miss_count_q + count_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      vaddr_mem_q[wptr_q] <= io.resp_vaddr_i;
      data_mem_q[wptr_q]  <= io.resp_data_i;
    end
  end

  assign io.resp_ready_o    = ready_s;
  assign io.instr_v_o       = ~empty_s;
  assign io.instr_vaddr_o   = vaddr_mem_q[rptr_q];
  assign io.instr_o         = data_mem_q[rptr_q];
  assign io.refetch_v_o     = refetch_v_s;
  assign io.refetch_vaddr_o = miss_vaddr_q;
  assign io.refetch_fill_o  = refetch_v_s;
  assign miss_count_o       = miss_count_q;
endmodule

// File: tb/tb_bp_fe_fetch_replay_queue.sv
// Scoreboard bench: a mode/occupancy reference model predicts handshakes and queues expected
// instructions; a separate monitor pops and compares them whenever the consumer dequeues.
module tb_bp_fe_fetch_replay_queue;
  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int ELS = 4;
  localparam int M_RUN = 0, M_REFETCH = 1, M_WAIT = 2;

  logic clk, reset_i;
  logic [15:0] miss_count;

  bp_fe_fetch_replay_queue_if #(.vaddr_width_p(VW), .instr_width_p(IW)) io ();

  bp_fe_fetch_replay_queue #(.vaddr_width_p(VW), .instr_width_p(IW), .els_p(ELS),
                             .count_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .io(io), .miss_count_o(miss_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [VW-1:0] va; logic [IW-1:0] d; } entry_t;
  entry_t exp_q[$];

  int            m_mode;
  int            m_occ;
  logic [VW-1:0] m_miss_va;
  int            m_cnt;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    m_mode = M_RUN; m_occ = 0; m_miss_va = '0; m_cnt = 0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (!reset_i && io.instr_v_o && io.instr_yumi_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_empty: DUT dequeued 0x%0h but nothing expected", io.instr_vaddr_o);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("head_vaddr", 64'(io.instr_vaddr_o), 64'(e.va));
        chk("head_data",  64'(io.instr_o),       64'(e.d));
      end
    end
  end

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic cycle(input logic v, input logic [VW-1:0] va, input logic [IW-1:0] d,
                       input logic m, input logic y, input logic rr);
    logic e_ready, hs, enq, deq, full, match;
    io.resp_v_i = v; io.resp_vaddr_i = va; io.resp_data_i = d; io.resp_miss_i = m;
    io.instr_yumi_i = y && (m_occ > 0);
    io.refetch_ready_i = rr;
    @(negedge clk);
    full  = (m_occ == ELS);
    match = (va == m_miss_va);
    if (m_mode == M_RUN)          e_ready = !full;
    else if (m_mode == M_REFETCH) e_ready = 1'b1;
    else                          e_ready = match ? !full : 1'b1;
    chk("resp_ready", 64'(io.resp_ready_o), 64'(e_ready));
    chk("instr_v",    64'(io.instr_v_o), 64'(m_occ > 0));
    chk("refetch_v",  64'(io.refetch_v_o), 64'(m_mode == M_REFETCH));
    chk("refetch_fill", 64'(io.refetch_fill_o), 64'(m_mode == M_REFETCH));
    chk("miss_count", 64'(miss_count), 64'(m_cnt));
    if (m_mode == M_REFETCH) chk("refetch_vaddr", 64'(io.refetch_vaddr_o), 64'(m_miss_va));
    @(posedge clk);
    hs  = v && e_ready;
    deq = io.instr_yumi_i;
    enq = 1'b0;
    if (m_mode == M_RUN) begin
      if (hs && m) begin
        m_miss_va = va; m_mode = M_REFETCH;
        if (m_cnt < 65535) m_cnt++;
      end else if (hs) enq = 1'b1;
    end else if (m_mode == M_REFETCH) begin
      if (rr) m_mode = M_WAIT;
    end else if (hs && match) begin
      if (m) begin
        m_mode = M_REFETCH;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        enq = 1'b1; m_mode = M_RUN;
      end
    end
    if (enq) exp_q.push_back('{va: va, d: d});
    m_occ = m_occ + int'(enq) - int'(deq);
    #1;
  endtask

  task automatic hit(input logic [VW-1:0] va, input logic [IW-1:0] d, input logic y);
    cycle(1'b1, va, d, 1'b0, y, 1'b0);
  endtask

  task automatic idle(input int n, input logic y, input logic rr);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, y, rr);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic mid_reset();
    #2;
    io.resp_v_i = 1'b0; io.instr_yumi_i = 1'b0; io.refetch_ready_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("rst_instr_v",   64'(io.instr_v_o), 64'(0));
    chk("rst_refetch_v", 64'(io.refetch_v_o), 64'(0));
    chk("rst_miss_cnt",  64'(miss_count), 64'(0));
    chk("rst_ready",     64'(io.resp_ready_o), 64'(1));
    model_clear();
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] va;
    reset_i = 1'b1;
    io.resp_v_i = 1'b0; io.resp_vaddr_i = '0; io.resp_data_i = '0; io.resp_miss_i = 1'b0;
    io.instr_yumi_i = 1'b0; io.refetch_ready_i = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("init_instr_v",   64'(io.instr_v_o), 64'(0));
    chk("init_refetch_v", 64'(io.refetch_v_o), 64'(0));
    chk("init_miss_cnt",  64'(miss_count), 64'(0));
    chk("init_ready",     64'(io.resp_ready_o), 64'(1));
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) hit(VW'(32'h1000 + 4 * i), IW'(32'hA000 + i), 1'b1);
    idle(3, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) hit(VW'(32'h1000 + 4 * i), IW'(32'hB000 + i), 1'b0);
    hit(VW'(32'h1010), IW'(32'hB004), 1'b1);
    hit(VW'(32'h1010), IW'(32'hB004), 1'b0);
    idle(6, 1'b1, 1'b0);

    cycle(1'b1, VW'(32'h2000), '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, VW'(32'h2004), IW'(32'h1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, VW'(32'h2000), IW'(32'h2), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    hit(VW'(32'h2004), IW'(32'h3), 1'b0);
    hit(VW'(32'h2000), IW'(32'hDEADBEEF), 1'b0);
    idle(2, 1'b1, 1'b0);

    cycle(1'b1, VW'(32'h2000), '0, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b1);
    cycle(1'b1, VW'(32'h2000), '0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    hit(VW'(32'h2000), IW'(32'h12345678), 1'b1);
    idle(2, 1'b1, 1'b0);

    hit(VW'(32'h3000), IW'(32'h30), 1'b0);
    hit(VW'(32'h3004), IW'(32'h34), 1'b0);
    cycle(1'b1, VW'(32'h3008), '0, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b1);
    mid_reset();

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       va = VW'(32'h1000);
        1:       va = VW'(32'h1004);
        2:       va = m_miss_va;
        default: va = VW'(32'h2000);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), va, IW'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 399) == 0) mid_reset();
    end
    idle(8, 1'b1, 1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
